uob_arbiter: RTL and testbench

UOB_ARBITER -- requirements
Module: uob_arbiter

---
 rtl/uob_arbiter_pkg.sv | 23 ++
 rtl/rr_select.sv | 36 +++
 rtl/uob_arbiter.sv | 146 ++++++++++++++
 tb/tb_uob_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uob_arbiter_pkg.sv
// Shared definitions for the unit output buffer arbiter: FSM encoding,
// default word width and the header fill bit.
package uob_arbiter_pkg;

    // Width of one unit output word when the instantiator does not override it
    localparam int UNIT_OUTPUT_WIDTH = 32;

    // The header word is OUT_WIDTH copies of this bit (all-ones)
    localparam logic HEADER_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_HEADER = 2'd2,
        ST_DATA   = 2'd3
    } uob_state_e;

    // Index width for n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first requesting unit at or after the start pointer,
// wrapping modulo N_UNITS. Purely combinational.
module rr_select #(
    parameter int N_UNITS = 8,
    parameter int IDX_W   = 3
) (
    input  logic [N_UNITS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_valid
);

    logic [N_UNITS-1:0] w_rot;
    int                 w_off;
    int                 w_sum;

    // Rotate requests so the pointer lands on bit 0, pick the lowest set bit,
    // then rotate the offset back into an absolute unit index
    always_comb begin
        w_rot   = N_UNITS'({i_req, i_req} >> i_ptr);
        w_off   = 0;
        o_valid = 1'b0;
        for (int k = N_UNITS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off   = k;
                o_valid = 1'b1;
            end
        end
        w_sum = int'(i_ptr) + w_off;
        if (w_sum >= N_UNITS) begin
            w_sum = w_sum - N_UNITS;
        end
        o_grant = IDX_W'(w_sum);
    end

endmodule

// File: rtl/uob_arbiter.sv
// Unit output buffer arbiter: grants one ready unit at a time (round-robin),
// strobes its read enable once, and forwards header + OUT_N_WORDS data words
// downstream with a single registered stage, flagging bad headers.
module uob_arbiter
    import uob_arbiter_pkg::*;
#(
    parameter int  N_UNITS     = 8,
    parameter int  OUT_WIDTH   = UNIT_OUTPUT_WIDTH,
    parameter int  OUT_N_WORDS = 24,
    localparam int UNIT_W      = idx_width(N_UNITS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_UNITS-1:0]           unit_empty,
    input  logic [N_UNITS*OUT_WIDTH-1:0] unit_dout,
    output logic [N_UNITS-1:0]           unit_rd_en,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         dout,
    output logic                         dout_valid,
    output logic                         dout_first,
    output logic                         dout_last,
    output logic [UNIT_W-1:0]            dout_unit,
    output logic                         err_header
);

    localparam int                   CNT_W       = $clog2(OUT_N_WORDS + 1);
    localparam logic [CNT_W-1:0]     LAST_CNT    = CNT_W'(OUT_N_WORDS - 1);
    localparam logic [UNIT_W-1:0]    LAST_UNIT   = UNIT_W'(N_UNITS - 1);
    localparam logic [OUT_WIDTH-1:0] HEADER_WORD = {OUT_WIDTH{HEADER_FILL}};

    uob_state_e           r_state;
    uob_state_e           w_next_state;
    logic [N_UNITS-1:0]   w_req;
    logic [UNIT_W-1:0]    w_grant;
    logic                 w_grant_vld;
    logic                 w_start;
    logic                 w_fwd;
    logic [OUT_WIDTH-1:0] w_word;
    logic [UNIT_W-1:0]    r_ptr;
    logic [UNIT_W-1:0]    r_sel;
    logic [CNT_W-1:0]     r_cnt;
    logic [N_UNITS-1:0]   r_rd_en;
    logic [OUT_WIDTH-1:0] r_dout;
    logic                 r_valid;
    logic                 r_first;
    logic                 r_last;
    logic [UNIT_W-1:0]    r_unit;
    logic                 r_err;

    assign w_req   = ~unit_empty;
    // Requests and out_ready only matter while idle
    assign w_start = (r_state == ST_IDLE) && out_ready && w_grant_vld;
    // Header arrives in HEADER, data words in DATA; both are forwarded
    assign w_fwd   = (r_state == ST_HEADER) || (r_state == ST_DATA);
    assign w_word  = unit_dout[int'(r_sel) * OUT_WIDTH +: OUT_WIDTH];

    rr_select #(
        .N_UNITS (N_UNITS),
        .IDX_W   (UNIT_W)
    ) u_rr_select (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_grant_vld)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one packet per grant, fixed length, no stalls
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next_state = ST_GRANT;
            ST_GRANT:  w_next_state = ST_HEADER;
            ST_HEADER: w_next_state = ST_DATA;
            ST_DATA:   if (r_cnt == LAST_CNT) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Grant: one-cycle read strobe, latch the selected unit, advance the pointer past it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_rd_en <= '0;
            if (w_start) begin
                r_rd_en <= N_UNITS'(1) << w_grant;
                r_sel   <= w_grant;
                r_ptr   <= (w_grant == LAST_UNIT) ? '0 : w_grant + 1'b1;
            end
        end
    end

    // Data word counter, cleared while the header is taken so DATA starts at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_HEADER) begin
            r_cnt <= '0;
        end else if (r_state == ST_DATA) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output stage: register the selected unit's word with framing flags; header check is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_unit  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_fwd;
            r_first <= (r_state == ST_HEADER);
            r_last  <= (r_state == ST_DATA) && (r_cnt == LAST_CNT);
            if (w_fwd) begin
                r_dout <= w_word;
                r_unit <= r_sel;
            end
            if ((r_state == ST_HEADER) && (w_word != HEADER_WORD)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign unit_rd_en = r_rd_en;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign dout_first = r_first;
    assign dout_last  = r_last;
    assign dout_unit  = r_unit;
    assign err_header = r_err;

endmodule

// File: tb/tb_uob_arbiter.sv
// Bench for uob_arbiter: behavioural unit models answer read strobes with
// randomly seeded packets; observed grants and forwarded packets are compared
// with a round-robin reference and the packets the units actually sent.
module tb_uob_arbiter;

    localparam int N   = 8;
    localparam int W   = 32;
    localparam int NW  = 24;
    localparam int PKT = NW + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   unit_empty;
    logic [N*W-1:0] unit_dout;
    logic [N-1:0]   unit_rd_en;
    logic           out_ready = 1'b0;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           dout_first;
    logic           dout_last;
    logic [2:0]     dout_unit;
    logic           err_header;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int model_last = -1;

    // unit models
    int           pending [N] = '{default: 0};
    bit           bad_hdr [N] = '{default: 0};
    bit           act     [N] = '{default: 0};
    int           widx    [N] = '{default: 0};
    logic [W-1:0] seed_r  [N];
    logic [W-1:0] hdr_r   [N];
    int           s_unit[$];
    logic [W-1:0] s_seed[$];
    logic [W-1:0] s_hdr[$];

    // observation logs
    logic [N-1:0] g_vec[$];
    int           g_cyc[$];
    int           g_idx[$];
    int           g_bad = 0;
    logic [W-1:0] o_words[$];
    int           o_unit[$];
    int           o_start[$];
    int           o_len[$];
    bit           o_err[$];
    logic [W-1:0] cur_words[$];
    bit           in_pkt = 0;
    int           cur_len = 0;
    int           cur_unit = 0;
    int           cur_start = 0;
    bit           cur_err = 0;
    int           trunc_cnt = 0;
    int           stray_cnt = 0;

    uob_arbiter #(
        .N_UNITS     (N),
        .OUT_WIDTH   (W),
        .OUT_N_WORDS (NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .unit_empty (unit_empty),
        .unit_dout  (unit_dout),
        .unit_rd_en (unit_rd_en),
        .out_ready  (out_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_first (dout_first),
        .dout_last  (dout_last),
        .dout_unit  (dout_unit),
        .err_header (err_header)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [W-1:0] wordgen(input logic [W-1:0] s, input int k);
        return s ^ (W'(k) * 32'h9E3779B9) ^ W'(k);
    endfunction

    // Reference arbitration rule: first requester from (last + 1) mod N
    function automatic int rr_next(input int last, input logic [N-1:0] req);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (last + 1 + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic int data_errs(input int p);
        int e;
        logic [W-1:0] exp_w;
        e = 0;
        if (p >= s_unit.size() || (p + 1) * PKT > o_words.size()) return PKT;
        for (int k = 0; k < PKT; k++) begin
            exp_w = (k == 0) ? s_hdr[p] : wordgen(s_seed[p], k - 1);
            if (o_words[p * PKT + k] !== exp_w) e++;
        end
        return e;
    endfunction

    // Unit models: header one cycle after the strobe, then NW data words, then junk
    initial begin
        unit_empty = '1;
        unit_dout  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (act[i]) begin
                    widx[i]++;
                    if (widx[i] == 0) unit_dout[i*W +: W] = hdr_r[i];
                    else if (widx[i] <= NW) unit_dout[i*W +: W] = wordgen(seed_r[i], widx[i] - 1);
                    else begin
                        act[i] = 0;
                        unit_dout[i*W +: W] = $urandom;
                    end
                end
                if (unit_rd_en[i]) begin
                    act[i]    = 1;
                    widx[i]   = -1;
                    seed_r[i] = $urandom;
                    hdr_r[i]  = bad_hdr[i] ? '0 : '1;
                    s_unit.push_back(i);
                    s_seed.push_back(seed_r[i]);
                    s_hdr.push_back(hdr_r[i]);
                    if (pending[i] > 0) pending[i]--;
                end
                unit_empty[i] = (pending[i] == 0);
            end
        end
    end

    // Passive recorder of grants and forwarded packets
    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (unit_rd_en != '0) begin
                g_vec.push_back(unit_rd_en);
                g_cyc.push_back(cyc);
                if (!$onehot(unit_rd_en)) g_bad++;
                idx = -1;
                for (int k = 0; k < N; k++) if (unit_rd_en[k]) idx = k;
                g_idx.push_back(idx);
            end
            if (!rst_n) begin
                in_pkt = 0;
            end else if (dout_valid) begin
                if (dout_first) begin
                    if (in_pkt) trunc_cnt++;
                    in_pkt    = 1;
                    cur_len   = 0;
                    cur_unit  = int'(dout_unit);
                    cur_start = cyc;
                    cur_err   = 0;
                    cur_words.delete();
                end
                if (!in_pkt) begin
                    stray_cnt++;
                end else begin
                    cur_words.push_back(dout);
                    if (int'(dout_unit) != cur_unit) cur_err = 1;
                    cur_len++;
                    if (dout_last) begin
                        o_unit.push_back(cur_unit);
                        o_start.push_back(cur_start);
                        o_len.push_back(cur_len);
                        o_err.push_back(cur_err);
                        foreach (cur_words[k]) o_words.push_back(cur_words[k]);
                        in_pkt = 0;
                    end
                end
            end else if (in_pkt) begin
                cur_err = 1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        g_vec.delete(); g_cyc.delete(); g_idx.delete();
        o_words.delete(); o_unit.delete(); o_start.delete(); o_len.delete(); o_err.delete();
        s_unit.delete(); s_seed.delete(); s_hdr.delete();
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        repeat (3) step();
        clear_logs();
        model_last = -1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_grants(input int n, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && g_idx.size() < n; c++) step();
        if (g_idx.size() >= n) ok = 1;
    endtask

    task automatic wait_pkts(input int n, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && o_unit.size() < n; c++) step();
        if (o_unit.size() >= n) ok = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pending[4] = 1;
        out_ready = 1'b1;
        repeat (4) step();
        n_checks++; if (unit_rd_en !== 8'h00) begin n_fail++; $display("FAIL reset_rd_en: got %h want 00", unit_rd_en); end
        n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        n_checks++; if (dout_first !== 1'b0) begin n_fail++; $display("FAIL reset_first: got %b want 0", dout_first); end
        n_checks++; if (dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", dout_last); end
        n_checks++; if (dout_unit !== 3'd0) begin n_fail++; $display("FAIL reset_unit: got %0d want 0", dout_unit); end
        n_checks++; if (err_header !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_header); end
        out_ready = 1'b0;
        pending[4] = 0;
        repeat (2) step();
        clear_logs();
        rst_n = 1'b1;
        model_last = -1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        pending[3] = 1;
        out_ready = 1'b1;
        wait_grants(1, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_grant_timeout: got 0 grants want 1"); end
        n_checks++; if ((g_vec.size() > 0 ? g_vec[0] : 8'h00) !== 8'h08) begin n_fail++; $display("FAIL single_rd_en: got %h want 08", (g_vec.size() > 0 ? g_vec[0] : 8'h00)); end
        wait_pkts(1, 60, ok);
        out_ready = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_pkt_timeout: got %0d packets want 1", o_unit.size()); end
        n_checks++; if (g_vec.size() !== 1) begin n_fail++; $display("FAIL single_strobe_cycles: got %0d want 1", g_vec.size()); end
        if (ok && g_cyc.size() > 0) begin
            n_checks++; if (o_unit[0] !== 3) begin n_fail++; $display("FAIL single_dout_unit: got %0d want 3", o_unit[0]); end
            n_checks++; if (o_len[0] !== PKT) begin n_fail++; $display("FAIL single_len: got %0d want %0d", o_len[0], PKT); end
            n_checks++; if (o_err[0] !== 1'b0) begin n_fail++; $display("FAIL single_framing: got gap/unit error want none"); end
            n_checks++; if (o_start[0] !== g_cyc[0] + 2) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", o_start[0] - g_cyc[0], 2); end
            n_checks++; if (o_words[0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL single_header: got %h want ffffffff", o_words[0]); end
            n_checks++; if (data_errs(0) !== 0) begin n_fail++; $display("FAIL single_data: got %0d bad words want 0", data_errs(0)); end
        end
        n_checks++; if (err_header !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err_header); end
        model_last = 3;
        repeat (3) step();
    endtask

    task automatic test_all_rotate();
        bit ok;
        int exp_g;
        do_reset();
        for (int i = 0; i < N; i++) pending[i] = 3;
        out_ready = 1'b1;
        wait_grants(9, 400, ok);
        out_ready = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL all_grant_timeout: got %0d grants want 9", g_idx.size()); end
        wait_pkts(9, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL all_pkt_timeout: got %0d packets want 9", o_unit.size()); end
        repeat (5) step();
        n_checks++; if (g_idx.size() !== 9) begin n_fail++; $display("FAIL all_grant_count: got %0d want 9", g_idx.size()); end
        for (int p = 0; p < 9 && p < g_idx.size() && p < o_unit.size(); p++) begin
            exp_g = rr_next(model_last, 8'hFF);
            model_last = exp_g;
            n_checks++; if (g_idx[p] !== exp_g) begin n_fail++; $display("FAIL all_order[%0d]: got %0d want %0d", p, g_idx[p], exp_g); end
            if (p > 0) begin
                n_checks++; if (g_cyc[p] - g_cyc[p-1] !== NW + 3) begin n_fail++; $display("FAIL all_period[%0d]: got %0d want %0d", p, g_cyc[p] - g_cyc[p-1], NW + 3); end
            end
            n_checks++; if (o_len[p] !== PKT || o_err[p] !== 1'b0) begin n_fail++; $display("FAIL all_len[%0d]: got len %0d err %b want %0d 0", p, o_len[p], o_err[p], PKT); end
            n_checks++; if (o_unit[p] !== exp_g || data_errs(p) !== 0) begin n_fail++; $display("FAIL all_pkt[%0d]: got unit %0d bad %0d want unit %0d bad 0", p, o_unit[p], data_errs(p), exp_g); end
        end
        for (int i = 0; i < N; i++) pending[i] = 0;
        repeat (3) step();
    endtask

    task automatic test_ready_gate();
        bit ok;
        int v;
        int exp_g;
        clear_logs();
        out_ready = 1'b0;
        pending[1] = 1;
        pending[6] = 1;
        repeat (10) step();
        n_checks++; if (g_vec.size() !== 0) begin n_fail++; $display("FAIL gate_no_grant: got %0d strobes want 0", g_vec.size()); end
        out_ready = 1'b1;
        v = cyc;
        wait_grants(1, 5, ok);
        n_checks++; if (!ok || g_cyc[0] !== v + 1) begin n_fail++; $display("FAIL gate_grant_delay: got %0d want %0d", ok ? g_cyc[0] - v : -1, 1); end
        wait_pkts(2, 120, ok);
        out_ready = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gate_pkt_timeout: got %0d packets want 2", o_unit.size()); end
        for (int p = 0; p < 2 && p < g_idx.size() && p < o_unit.size(); p++) begin
            exp_g = rr_next(model_last, (p == 0) ? 8'h42 : 8'h40);
            model_last = exp_g;
            n_checks++; if (g_idx[p] !== exp_g || o_unit[p] !== exp_g) begin n_fail++; $display("FAIL gate_order[%0d]: got %0d/%0d want %0d", p, g_idx[p], o_unit[p], exp_g); end
            n_checks++; if (data_errs(p) !== 0 || o_len[p] !== PKT) begin n_fail++; $display("FAIL gate_pkt[%0d]: got bad %0d len %0d want 0 %0d", p, data_errs(p), o_len[p], PKT); end
        end
        repeat (3) step();
    endtask

    task automatic test_bad_header();
        bit ok;
        clear_logs();
        n_checks++; if (err_header !== 1'b0) begin n_fail++; $display("FAIL badhdr_pre: got %b want 0", err_header); end
        bad_hdr[5] = 1;
        pending[5] = 1;
        out_ready = 1'b1;
        wait_pkts(1, 80, ok);
        bad_hdr[5] = 0;
        out_ready = 1'b0;
        n_checks++; if (!ok || o_unit[0] !== 5) begin n_fail++; $display("FAIL badhdr_fwd: got %0d packets want unit 5 forwarded", o_unit.size()); end
        n_checks++; if (ok && (o_words[0] !== 32'h0 || data_errs(0) !== 0)) begin n_fail++; $display("FAIL badhdr_data: got header %h bad %0d want 0 0", o_words[0], data_errs(0)); end
        n_checks++; if (err_header !== 1'b1) begin n_fail++; $display("FAIL badhdr_set: got %b want 1", err_header); end
        model_last = 5;
        pending[2] = 1;
        out_ready = 1'b1;
        wait_pkts(2, 80, ok);
        out_ready = 1'b0;
        n_checks++; if (!ok || o_unit[1] !== 2 || data_errs(1) !== 0) begin n_fail++; $display("FAIL badhdr_good_pkt: got %0d packets want good unit 2 packet", o_unit.size()); end
        n_checks++; if (err_header !== 1'b1) begin n_fail++; $display("FAIL badhdr_sticky: got %b want 1", err_header); end
        model_last = 2;
        repeat (3) step();
        do_reset();
        n_checks++; if (err_header !== 1'b0) begin n_fail++; $display("FAIL badhdr_cleared: got %b want 0", err_header); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        clear_logs();
        pending[0] = 1;
        pending[2] = 1;
        out_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 80 && !found; c++) begin
            step();
            if (rst_n && in_pkt && dout_valid && cur_len == 12) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_reach_word10: got timeout want data word 10"); end
        n_checks++; if (s_seed.size() == 0 || dout !== wordgen(s_seed[0], 10)) begin n_fail++; $display("FAIL rstmid_word10: got %h want data word 10", dout); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({unit_rd_en, dout, dout_valid, dout_first, dout_last, dout_unit, err_header} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs_zero: got rd_en %h dout %h v%b f%b l%b u%0d e%b want all 0", unit_rd_en, dout, dout_valid, dout_first, dout_last, dout_unit, err_header);
        end
        repeat (30) step();
        n_checks++; if (dout_valid !== 1'b0 || unit_rd_en !== 8'h00) begin n_fail++; $display("FAIL rstmid_held: got v%b rd_en %h want 0 00", dout_valid, unit_rd_en); end
        clear_logs();
        pending[0] = 1;
        step();
        rst_n = 1'b1;
        model_last = -1;
        wait_grants(1, 10, ok);
        out_ready = 1'b0;
        n_checks++; if (!ok || g_idx[0] !== rr_next(model_last, 8'h05)) begin n_fail++; $display("FAIL rstmid_regrant: got %0d want %0d", ok ? g_idx[0] : -1, rr_next(model_last, 8'h05)); end
        model_last = 0;
        wait_pkts(1, 60, ok);
        n_checks++; if (!ok || data_errs(0) !== 0 || o_len[0] !== PKT) begin n_fail++; $display("FAIL rstmid_next_pkt: got %0d packets want one clean packet", o_unit.size()); end
        pending[2] = 0;
        repeat (3) step();
    endtask

    task automatic test_random();
        bit ok;
        int total;
        int last;
        int pend [N];
        int exp_q[$];
        logic [N-1:0] req;
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            exp_q.delete();
            total = 0;
            for (int i = 0; i < N; i++) begin
                pending[i] = $urandom_range(0, 2);
            end
            pending[$urandom_range(0, N - 1)] += 1;
            for (int i = 0; i < N; i++) begin
                pend[i] = pending[i];
                total += pending[i];
            end
            last = model_last;
            for (int p = 0; p < total; p++) begin
                for (int i = 0; i < N; i++) req[i] = (pend[i] > 0);
                last = rr_next(last, req);
                exp_q.push_back(last);
                pend[last]--;
            end
            ok = 0;
            for (int c = 0; c < 4000 && !ok; c++) begin
                step();
                out_ready = ($urandom_range(0, 3) != 0);
                if (o_unit.size() >= total) ok = 1;
            end
            out_ready = 1'b0;
            repeat (30) step();
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d packets want %0d", r, o_unit.size(), total); end
            n_checks++; if (g_idx.size() !== total) begin n_fail++; $display("FAIL rand%0d_grants: got %0d want %0d", r, g_idx.size(), total); end
            for (int p = 0; p < total && p < g_idx.size() && p < o_unit.size(); p++) begin
                n_checks++; if (g_idx[p] !== exp_q[p] || o_unit[p] !== exp_q[p]) begin n_fail++; $display("FAIL rand%0d_order[%0d]: got %0d/%0d want %0d", r, p, g_idx[p], o_unit[p], exp_q[p]); end
                n_checks++; if (o_len[p] !== PKT || o_err[p] !== 1'b0 || data_errs(p) !== 0) begin n_fail++; $display("FAIL rand%0d_pkt[%0d]: got len %0d err %b bad %0d want %0d 0 0", r, p, o_len[p], o_err[p], data_errs(p), PKT); end
            end
            if (total > 0) model_last = exp_q[total - 1];
        end
        n_checks++; if (g_bad !== 0) begin n_fail++; $display("FAIL strobe_onehot: got %0d bad strobes want 0", g_bad); end
        n_checks++; if (trunc_cnt !== 0 || stray_cnt !== 0) begin n_fail++; $display("FAIL framing_global: got trunc %0d stray %0d want 0 0", trunc_cnt, stray_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rotate();
        test_ready_gate();
        test_bad_header();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
